// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the memory arbiter and mem_responder
interface mem_responder_if;
    logic        req;
    logic [31:0] addr_ram;
    logic [31:0] wdata_ram;
    logic [3:0]  we_ram;
    logic [31:0] rdata_ram;
    logic        ready;

    modport master (output req, addr_ram, wdata_ram, we_ram, input rdata_ram, ready);
    modport slave  (input req, addr_ram, wdata_ram, we_ram, output rdata_ram, ready);
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - RAM (text/data/stack) plus MMIO responder with programmable wait states
module mem_responder #(
    parameter int ADDR_BITS   = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_responder_if.slave    bus,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out
);
    localparam int DEPTH = 3 * (2 ** ADDR_BITS);
    localparam int WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [WCW-1:0]    wcnt;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        we_q;
    logic [31:0]       acc_addr, acc_wdata;
    logic [3:0]        acc_we;
    logic [1:0]        acc_region;
    logic [ADDR_BITS+1:0] ram_idx;
    logic              commit;
    logic [31:0]       cyc, sync1, sync2, scratch, rdata_q, mmio_rd;
    logic [31:0]       mem [DEPTH];
    logic              unused_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.req)
                        state_nxt = (bus.addr_ram[17:16] != 2'd3 && WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            S_WAIT: if (wcnt == '0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // In IDLE the accept and the commit can share an edge, so use the live inputs there
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        if (state == S_IDLE) begin
            acc_addr  = bus.addr_ram;
            acc_wdata = bus.wdata_ram;
            acc_we    = bus.we_ram;
        end
    end

    assign acc_region = acc_addr[17:16];
    assign ram_idx    = {acc_region, acc_addr[ADDR_BITS+1:2]};
    assign commit     = (state_nxt == S_DONE) && (state != S_DONE);
    assign unused_ok  = ^{acc_addr[31:18], acc_addr[15:0]};

    always_comb begin
        mmio_rd = '0;
        case (acc_addr[7:0])
            8'h00:   mmio_rd = cyc;
            8'h04:   mmio_rd = gpio_out;
            8'h08:   mmio_rd = sync2;
            8'h0C:   mmio_rd = scratch;
            default: mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            cyc      <= '0;
            sync1    <= '0;
            sync2    <= '0;
            gpio_out <= '0;
            scratch  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc + 32'd1;
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (state == S_IDLE && bus.req) begin
                addr_q  <= bus.addr_ram;
                wdata_q <= bus.wdata_ram;
                we_q    <= bus.we_ram;
                wcnt    <= WCW'(WAIT_CYCLES - 1);
            end else if (state == S_WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (commit) begin
                if (acc_region == 2'd3) begin
                    for (int b = 0; b < 4; b++) begin
                        if (acc_we[b] && acc_addr[7:0] == 8'h04) gpio_out[8*b +: 8] <= acc_wdata[8*b +: 8];
                        if (acc_we[b] && acc_addr[7:0] == 8'h0C) scratch[8*b +: 8]  <= acc_wdata[8*b +: 8];
                    end
                    rdata_q <= (acc_we == 4'h0) ? mmio_rd : 32'h0;
                end else begin
                    rdata_q <= (acc_we == 4'h0) ? mem[ram_idx] : 32'h0;
                end
            end
        end
    end

    // RAM is not reset; rst_n gating keeps an access accepted during reset from writing
    always_ff @(posedge clk) begin
        if (rst_n && commit && acc_region != 2'd3) begin
            for (int b = 0; b < 4; b++)
                if (acc_we[b]) mem[ram_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
    end

    assign bus.ready     = (state == S_DONE);
    assign bus.rdata_ram = (state == S_DONE) ? rdata_q : 32'h0;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a word-level model
module tb_mem_responder;
    localparam int AB = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out1, gpio_out3;
    logic        t_req, t_sel;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_we;

    always #5 clk = ~clk;

    mem_responder_if bus1();
    mem_responder_if bus3();

    assign bus1.req = t_req & ~t_sel;  assign bus3.req = t_req & t_sel;
    assign bus1.addr_ram = t_addr;     assign bus3.addr_ram = t_addr;
    assign bus1.wdata_ram = t_wdata;   assign bus3.wdata_ram = t_wdata;
    assign bus1.we_ram = t_we;         assign bus3.we_ram = t_we;

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .gpio_in(gpio_in), .gpio_out(gpio_out1));
    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .gpio_in(gpio_in), .gpio_out(gpio_out3));

    wire        rdy  = t_sel ? bus3.ready : bus1.ready;
    wire [31:0] rdat = t_sel ? bus3.rdata_ram : bus1.rdata_ram;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // cycles elapsed since reset release, the value the counter register should hold
    logic [31:0] tb_cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 32'h0;
        else        tb_cyc <= tb_cyc + 32'h1;

    logic [31:0] ref_mem [int];
    logic [31:0] ref_gpio, ref_scratch, gpio_at_done;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'(a[17:16]) * (2 ** AB) + int'((a >> 2) & ((32'h1 << AB) - 1));
    endfunction

    task automatic access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                          output logic [31:0] rd, output logic [31:0] cyc_acc);
        int lat, exp_lat;
        @(negedge clk);
        t_addr = a; t_wdata = w; t_we = we; t_req = 1'b1;
        @(posedge clk); #1;
        cyc_acc = tb_cyc - 32'h1;
        lat = 1;
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (a[17:16] == 2'd3) ? 1 : (t_sel ? 4 : 2);
        check("latency", 32'(lat), 32'(exp_lat));
        rd = rdat;
        gpio_at_done = gpio_out1;
        t_req = 1'b0; t_we = 4'h0;
        if (we != 4'h0) check("write_rdata_zero", rd, 32'h0);
        @(posedge clk); #1;
        check("ready_pulse", {31'h0, rdy}, 32'h0);
        check("rdata_idle", rdat, 32'h0);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we, output logic [31:0] rd);
        logic [31:0] c, exp;
        int k;
        access(a, w, we, rd, c);
        if (a[17:16] != 2'd3) begin
            k = key_of(a);
            if (we != 4'h0) ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'h0, w, we);
            else if (ref_mem.exists(k)) check("ram_read", rd, ref_mem[k]);
        end else begin
            if (we != 4'h0 && a[7:0] == 8'h04) ref_gpio    = merge(ref_gpio, w, we);
            if (we != 4'h0 && a[7:0] == 8'h0C) ref_scratch = merge(ref_scratch, w, we);
            check("gpio_out_at_done", gpio_at_done, ref_gpio);
            if (we == 4'h0) begin
                case (a[7:0])
                    8'h00:   exp = c;
                    8'h04:   exp = ref_gpio;
                    8'h08:   exp = gpio_in;
                    8'h0C:   exp = ref_scratch;
                    default: exp = 32'h0;
                endcase
                check("mmio_read", rd, exp);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, c, a, w;
        logic [3:0]  we;
        logic        seen;
        int          k;

        t_req = 0; t_sel = 0; t_addr = 0; t_wdata = 0; t_we = 0; gpio_in = 0;
        ref_gpio = 0; ref_scratch = 0;
        rst_n = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            t_req = 1'($urandom); t_addr = $urandom; t_wdata = $urandom; t_we = 4'($urandom); gpio_in = $urandom;
            @(posedge clk); #1;
            check("reset_ready", {31'h0, bus1.ready}, 32'h0);
            check("reset_rdata", bus1.rdata_ram, 32'h0);
            check("reset_gpio_out", gpio_out1, 32'h0);
        end
        @(negedge clk);
        t_req = 0; t_we = 0; gpio_in = 0;
        rst_n = 1'b1;

        access(32'h0003_0000, 32'h0, 4'h0, rd, c);
        check("counter_after_reset", rd, c);
        check("counter_small", {31'h0, rd < 32'd16}, 32'h1);

        txn(32'h0001_0040, 32'hDEADBEEF, 4'hF, rd);
        txn(32'h0001_0040, 32'h0, 4'h0, rd);
        check("word_write", rd, 32'hDEADBEEF);
        txn(32'h0001_0040, 32'h11223344, 4'h5, rd);
        txn(32'h0001_0040, 32'h0, 4'h0, rd);
        check("byte_enables", rd, 32'hDE22BE44);

        txn(32'h0000_0100, 32'h1, 4'hF, rd);
        txn(32'h0001_0100, 32'h2, 4'hF, rd);
        txn(32'h0002_0100, 32'h3, 4'hF, rd);
        for (int r = 0; r < 3; r++) begin
            txn(32'(r) << 16 | 32'h100, 32'h0, 4'h0, rd);
            check("region_sep", rd, 32'(r + 1));
        end
        txn(32'h0001_0102, 32'h0, 4'h0, rd);
        check("alias_low_bits", rd, 32'h2);

        txn(32'h0003_0004, 32'h0000_00A5, 4'h1, rd);
        check("gpio_out_a5", gpio_at_done, 32'hA5);
        gpio_in = 32'h0000_0F0F;
        repeat (3) @(posedge clk);
        txn(32'h0003_0008, 32'h0, 4'h0, rd);
        check("gpio_in_sync", rd, 32'h0000_0F0F);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(5, 0))
                0, 1, 2, 3: begin
                    a = (32'($urandom_range(2, 0)) << 16) | (32'($urandom_range(7, 0)) << 2) | 32'($urandom_range(3, 0));
                    k = key_of(a);
                    if (!ref_mem.exists(k) || $urandom_range(1, 0) == 0) begin
                        we = ref_mem.exists(k) ? 4'($urandom_range(15, 1)) : 4'hF;
                        txn(a, $urandom, we, rd);
                    end else begin
                        txn(a, 32'h0, 4'h0, rd);
                    end
                end
                4: begin
                    case ($urandom_range(5, 0))
                        0: a = 32'h00; 1: a = 32'h04; 2: a = 32'h08;
                        3: a = 32'h0C; 4: a = 32'h10; default: a = 32'h40;
                    endcase
                    a = a | 32'h0003_0000 | ($urandom & 32'h0000_FF00);
                    we = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                    w = $urandom;
                    txn(a, w, we, rd);
                end
                default: begin
                    gpio_in = $urandom;
                    repeat (3) @(posedge clk);
                    txn(32'h0003_0008, 32'h0, 4'h0, rd);
                end
            endcase
        end

        t_sel = 1'b1;
        access(32'h0001_0000, 32'h1111_1111, 4'hF, rd, c);
        access(32'h0001_0000, 32'h0, 4'h0, rd, c);
        check("w3_prev_contents", rd, 32'h1111_1111);
        @(negedge clk);
        t_addr = 32'h0001_0000; t_wdata = 32'hCAFEF00D; t_we = 4'hF; t_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        t_req = 1'b0; t_we = 4'h0;
        #1;
        check("midwait_ready_drop", {31'h0, rdy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rdy) seen = 1'b1;
        end
        check("midwait_no_ready", {31'h0, seen}, 32'h0);
        access(32'h0001_0000, 32'h0, 4'h0, rd, c);
        check("midwait_write_dropped", rd, 32'h1111_1111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
